seg7_scan_decoder: RTL and testbench

- Reader-side counterpart of the team's hex-to-7-segment encoder.
- Watches a multiplexed, active-high digit-select and 8-bit segment bus, as driven onto a multi-digit 7-segment display.
- Waits for each digit's pattern to be stable, then decodes it back to a hex nibble, a decimal-point flag and an error flag.
- Signals when every digit has been captured at least once (a full frame). Used for display loop-back self-test and scoreboarding.

---
 rtl/seg7_scan_decoder_if.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 101 ++++++++++
 tb/tb_seg7_scan_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if: multiplexed 7-segment display bus plus the decoded results read back from it
//   an           digit select, active-high, one-hot selects a digit
//   seg          segments a..g in [6:0], dp in [7], 1 = lit
//   hex_out      decoded nibble per digit, digit n in [4n+3:4n]
//   dp_out       captured dp per digit
//   digit_err    last capture of that digit was not a hex glyph
//   sample_valid one-cycle pulse per capture, sample_idx names the digit
//   frame_valid  one-cycle pulse once every digit has been captured
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 4
);
    localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    logic [DIGITS-1:0] an;
    logic [7:0] seg;
    logic [4*DIGITS-1:0] hex_out;
    logic [DIGITS-1:0] dp_out;
    logic [DIGITS-1:0] digit_err;
    logic sample_valid;
    logic [IDX_W-1:0] sample_idx;
    logic frame_valid;
    modport master (
        output an, seg,
        input hex_out, dp_out, digit_err, sample_valid, sample_idx, frame_valid
    );
    modport slave (
        input an, seg,
        output hex_out, dp_out, digit_err, sample_valid, sample_idx, frame_valid
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: waits for each multiplexed digit to settle, then decodes it back to hex, dp and error flags
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  seg7_scan_decoder_if slave: an/seg in, decoded digits and capture/frame pulses out
module seg7_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    seg7_scan_decoder_if.slave bus
);
    localparam int IDX_W = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic [6:0] TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIGITS+7:0] in_q, prev_q;
    logic [DIGITS-1:0] an_q, seen_q, dp_q, err_q;
    logic [7:0] seg_q;
    logic [4*DIGITS-1:0] hex_q;
    logic [IDX_W-1:0] idx_q, idx;
    logic valid_q, frame_q, capture, match, same, one_hot;
    logic [3:0] nib;
    assign an_q = in_q[DIGITS+7:8];
    assign seg_q = in_q[7:0];
    assign same = in_q == prev_q;
    assign one_hot = $onehot(an_q);
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        capture = 1'b0;
        if (!one_hot) begin
            state_d = IDLE;
            cnt_d = '0;
        end else if (state_q == SETTLE && same) begin
            cnt_d = cnt_q >= STABLE ? cnt_q : cnt_q + 1'b1;
            capture = cnt_d == STABLE;
            state_d = capture ? HOLD : SETTLE;
        end else if (!(state_q == HOLD && same)) begin
            // IDLE always restarts, even on an already-stable pattern out of reset
            state_d = SETTLE;
            cnt_d = CNT_W'(1);
        end
    end
    always_comb begin
        nib = '0;
        match = 1'b0;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg_q[6:0] == TBL[i]) begin
                nib = 4'(i);
                match = 1'b1;
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (an_q[i]) idx = IDX_W'(i);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= '0;
            prev_q <= '0;
            state_q <= IDLE;
            cnt_q <= '0;
            seen_q <= '0;
            hex_q <= '0;
            dp_q <= '0;
            err_q <= '0;
            idx_q <= '0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            in_q <= {bus.an, bus.seg};
            prev_q <= in_q;
            state_q <= state_d;
            cnt_q <= cnt_d;
            valid_q <= capture;
            frame_q <= &seen_q;
            // a full mask clears one edge after it fills; a capture on that edge survives
            seen_q <= (&seen_q ? '0 : seen_q) | (capture ? an_q : '0);
            if (capture) begin
                idx_q <= idx;
                hex_q[4*idx +: 4] <= nib;
                dp_q[idx] <= seg_q[7];
                err_q[idx] <= !match;
            end
        end
    end
    assign bus.hex_out = hex_q;
    assign bus.dp_out = dp_q;
    assign bus.digit_err = err_q;
    assign bus.sample_valid = valid_q;
    assign bus.sample_idx = idx_q;
    assign bus.frame_valid = frame_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random scans checked against a run-length reference model
module tb_seg7_scan_decoder;
    localparam int DIGITS = 4;
    localparam int STABLE = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();
    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    logic [6:0] tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [11:0] ls = '0;
    int run = 1;
    logic [15:0] e_hex = '0;
    logic [3:0] e_dp = '0, e_err = '0, seen = '0;
    logic e_sv = 1'b0, e_fv = 1'b0;
    logic [1:0] e_idx = '0;
    // A capture fires on the edge after a one-hot sample has repeated exactly STABLE times in a row.
    task automatic model();
        logic [11:0] s;
        bit cap, hit;
        int n;
        s = {bus.an, bus.seg};
        if (rst) begin
            ls = '0; run = 1; e_hex = '0; e_dp = '0; e_err = '0; seen = '0;
            e_sv = 1'b0; e_fv = 1'b0; e_idx = '0;
            return;
        end
        cap = run == STABLE && $countones(ls[11:8]) == 1;
        e_fv = seen == 4'hF;
        if (e_fv) seen = '0;
        e_sv = cap;
        if (cap) begin
            n = 0;
            for (int i = 0; i < DIGITS; i++) if (ls[8+i]) n = i;
            hit = 0;
            e_hex[4*n +: 4] = 4'h0;
            for (int v = 0; v < 16; v++) begin
                if (tbl[v] == ls[6:0]) begin
                    hit = 1;
                    e_hex[4*n +: 4] = 4'(v);
                end
            end
            e_err[n] = !hit;
            e_dp[n] = ls[7];
            seen[n] = 1'b1;
            e_idx = 2'(n);
        end
        if (s == ls) run = run < 1000 ? run + 1 : run;
        else begin
            ls = s;
            run = 1;
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model();
        cyc++;
        #1;
    endtask
    function automatic logic [27:0] obs();
        return {bus.hex_out, bus.dp_out, bus.digit_err, bus.sample_valid,
                bus.sample_valid ? bus.sample_idx : 2'd0, bus.frame_valid};
    endfunction
    function automatic logic [27:0] expv();
        return {e_hex, e_dp, e_err, e_sv, e_sv ? e_idx : 2'd0, e_fv};
    endfunction
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.an = 4'($urandom);
            bus.seg = 8'($urandom);
            tick();
            checks++;
            if (obs() !== 28'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d got %h exp %h", cyc, obs(), 28'h0);
            end
        end
        rst = 1'b0;
        bus.an = '0;
        for (int k = 0; k < 3; k++) begin
            bus.seg = 8'($urandom);
            tick();
            checks++;
            if (bus.sample_valid !== 1'b0 || bus.frame_valid !== 1'b0 || obs() !== expv()) begin
                errors++;
                $display("FAIL reset_release cyc %0d got %h exp %h", cyc, obs(), expv());
            end
        end
    endtask
    task automatic test_single_capture();
        int pulses = 0, at = -1;
        logic [1:0] pidx = '1;
        bus.an = 4'b0001;
        bus.seg = 8'h4F;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.sample_valid) begin
                pulses++;
                at = k;
                pidx = bus.sample_idx;
            end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL single_model cyc %0d got %h exp %h", cyc, obs(), expv());
            end
        end
        checks++;
        if (pulses !== 1 || at !== 4 || pidx !== 2'd0) begin
            errors++;
            $display("FAIL single_timing got pulses=%0d at=%0d idx=%0d exp pulses=1 at=4 idx=0", pulses, at, pidx);
        end
        checks++;
        if ({bus.hex_out[3:0], bus.digit_err[0], bus.dp_out[0]} !== {4'h3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_value got hex=%h err=%b dp=%b exp hex=3 err=0 dp=0",
                     bus.hex_out[3:0], bus.digit_err[0], bus.dp_out[0]);
        end
    endtask
    task automatic test_full_frame();
        logic [7:0] pat [4] = '{8'h06, 8'h5B, 8'hF7, 8'h71};
        int caps = 0, frames = 0, last_cap = -1, frame_at = -1;
        logic [7:0] idxs = '0;
        for (int d = 0; d < 4; d++) begin
            bus.an = 4'(1 << d);
            bus.seg = pat[d];
            for (int k = 0; k < 6; k++) begin
                tick();
                if (bus.sample_valid) begin
                    if (caps < 4) idxs[2*caps +: 2] = bus.sample_idx;
                    caps++;
                    last_cap = cyc;
                end
                if (bus.frame_valid) begin
                    frames++;
                    frame_at = cyc;
                end
                checks++;
                if (obs() !== expv()) begin
                    errors++;
                    $display("FAIL frame_model cyc %0d got %h exp %h", cyc, obs(), expv());
                end
            end
        end
        checks++;
        if (caps !== 4 || idxs !== 8'hE4) begin
            errors++;
            $display("FAIL frame_captures got caps=%0d idxs=%h exp caps=4 idxs=e4", caps, idxs);
        end
        checks++;
        if (frames !== 1 || frame_at !== last_cap + 1) begin
            errors++;
            $display("FAIL frame_pulse got frames=%0d at=%0d exp frames=1 at=%0d", frames, frame_at, last_cap + 1);
        end
        checks++;
        if ({bus.hex_out, bus.dp_out, bus.digit_err} !== {16'hFA21, 4'b0100, 4'b0000}) begin
            errors++;
            $display("FAIL frame_value got hex=%h dp=%b err=%b exp hex=fa21 dp=0100 err=0000",
                     bus.hex_out, bus.dp_out, bus.digit_err);
        end
    endtask
    task automatic test_glitch();
        int pulses = 0, at = -1;
        logic [27:0] snap;
        bus.an = 4'b0010;
        bus.seg = 8'h06;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.sample_valid) pulses++;
        end
        bus.seg = 8'h5B;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.sample_valid) begin
                pulses++;
                at = k;
            end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL glitch_model cyc %0d got %h exp %h", cyc, obs(), expv());
            end
        end
        checks++;
        if (pulses !== 1 || at !== 4 || bus.hex_out[7:4] !== 4'h2) begin
            errors++;
            $display("FAIL glitch_capture got pulses=%0d at=%0d nib=%h exp pulses=1 at=4 nib=2",
                     pulses, at, bus.hex_out[7:4]);
        end
        snap = obs();
        pulses = 0;
        bus.an = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.sample_valid) pulses++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL twohot_model cyc %0d got %h exp %h", cyc, obs(), expv());
            end
        end
        checks++;
        if (pulses !== 0 || obs() !== snap) begin
            errors++;
            $display("FAIL twohot_hold got pulses=%0d out=%h exp pulses=0 out=%h", pulses, obs(), snap);
        end
    endtask
    task automatic test_illegal();
        int pulses = 0;
        bus.an = 4'b0100;
        bus.seg = 8'h49;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.sample_valid) pulses++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL illegal_model cyc %0d got %h exp %h", cyc, obs(), expv());
            end
        end
        checks++;
        if (pulses !== 1 || bus.digit_err[2] !== 1'b1 || bus.hex_out[11:8] !== 4'h0) begin
            errors++;
            $display("FAIL illegal_err got pulses=%0d err=%b nib=%h exp pulses=1 err=1 nib=0",
                     pulses, bus.digit_err[2], bus.hex_out[11:8]);
        end
        pulses = 0;
        bus.seg = 8'h3F;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.sample_valid) pulses++;
        end
        checks++;
        if (pulses !== 1 || bus.digit_err[2] !== 1'b0 || bus.hex_out[11:8] !== 4'h0) begin
            errors++;
            $display("FAIL illegal_recover got pulses=%0d err=%b nib=%h exp pulses=1 err=0 nib=0",
                     pulses, bus.digit_err[2], bus.hex_out[11:8]);
        end
    endtask
    task automatic test_reset_settle();
        int pulses = 0, at = -1;
        bus.an = 4'b0001;
        bus.seg = 8'h6D;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.sample_valid) pulses++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs() !== 28'h0 || pulses !== 0) begin
            errors++;
            $display("FAIL settle_reset got out=%h pulses=%0d exp out=0 pulses=0", obs(), pulses);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.sample_valid) begin
                pulses++;
                at = k;
            end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL settle_model cyc %0d got %h exp %h", cyc, obs(), expv());
            end
        end
        checks++;
        if (pulses !== 1 || at !== 4 || bus.hex_out !== 16'h0005) begin
            errors++;
            $display("FAIL settle_recapture got pulses=%0d at=%0d hex=%h exp pulses=1 at=4 hex=0005",
                     pulses, at, bus.hex_out);
        end
    endtask
    task automatic test_random();
        int hold = 0, caps = 0, frames = 0;
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 8);
                case ($urandom_range(0, 9))
                    0: bus.an = '0;
                    1: bus.an = 4'($urandom);
                    default: bus.an = 4'(1 << $urandom_range(0, 3));
                endcase
                if ($urandom_range(0, 3) != 0) bus.seg = {1'($urandom), tbl[$urandom_range(0, 15)]};
                else bus.seg = 8'($urandom);
            end
            hold--;
            rst = $urandom_range(0, 99) == 0;
            tick();
            if (bus.sample_valid) caps++;
            if (bus.frame_valid) frames++;
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random_model cyc %0d got %h exp %h", cyc, obs(), expv());
            end
        end
        rst = 1'b0;
        checks++;
        if (caps < 50 || frames < 1) begin
            errors++;
            $display("FAIL random_activity got caps=%0d frames=%0d exp caps>=50 frames>=1", caps, frames);
        end
    endtask
    initial begin
        bus.an = '0;
        bus.seg = '0;
        test_reset();
        test_single_capture();
        test_full_frame();
        test_glitch();
        test_illegal();
        test_reset_settle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
